// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_reader shared types.
// FSM state encoding and the stream handshake helper.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic hs(
    input logic v,
    input logic r
  );
    return v & r;
  endfunction

endpackage

// File: rtl/ram_burst_reader_fifo.sv
// stream_fifo: first-word-fall-through FIFO.
// Output reads as zero while empty.
module stream_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = o_empty ? '0 : r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: burst reads from a fixed-latency RAM
// into a credit-guarded valid/ready stream.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 9,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_ren,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RL = RD_LATENCY;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_raddr;
  logic [LEN_W-1:0]  r_rem;
  logic              r_ren;
  logic              r_ren_last;
  logic              r_zero;
  logic              r_done;
  logic [RL-1:0]     r_sr_v;
  logic [RL-1:0]     r_sr_l;

  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_accept;
  logic              w_credit;
  logic [15:0]       w_outstanding;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W:0]   w_dout;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;

  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = r_done;
  assign o_raddr = r_raddr;
  assign o_ren   = r_ren;
  assign o_valid = !w_empty;
  assign o_data  = w_dout[DATA_W-1:0];
  assign o_last  = w_dout[DATA_W];

  assign w_push   = r_sr_v[RL-1];
  assign w_pop    = hs(o_valid, i_ready);
  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_issue_addr = (r_state == S_IDLE) ? i_base_addr : r_addr;

  // Every issued word owns a FIFO slot until it is popped.
  always_comb begin
    w_outstanding = 16'(w_count) + {15'd0, r_ren};
    for (int i = 0; i < RL; i++) begin
      w_outstanding = w_outstanding + {15'd0, r_sr_v[i]};
    end
    w_credit = (w_outstanding < 16'(FIFO_DEPTH));
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_issue      = 1'b1;
            w_issue_last = (i_len == LEN_W'(1));
            w_state_nxt  = w_issue_last ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_credit) begin
          w_issue      = 1'b1;
          w_issue_last = (r_rem == LEN_W'(1));
          if (w_issue_last) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (r_zero || (w_pop && o_last)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_raddr    <= '0;
      r_rem      <= '0;
      r_ren      <= 1'b0;
      r_ren_last <= 1'b0;
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
      r_sr_v     <= '0;
      r_sr_l     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ren      <= w_issue;
      r_ren_last <= w_issue_last;
      r_done     <= (r_state == S_DRAIN) &&
                    (w_state_nxt == S_IDLE);
      r_sr_v     <= (r_sr_v << 1) | RL'(r_ren);
      r_sr_l     <= (r_sr_l << 1) | RL'(r_ren_last);
      if (w_issue) begin
        r_raddr <= w_issue_addr;
        r_addr  <= w_issue_addr + ADDR_W'(1);
      end
      if (w_accept) begin
        r_zero <= (i_len == '0);
        r_rem  <= (i_len == '0) ? '0 : i_len - LEN_W'(1);
      end else if (w_issue) begin
        r_rem  <= r_rem - LEN_W'(1);
      end
    end
  end

  stream_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({r_sr_l[RL-1], i_rdata}),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(w_push && w_full)
  );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: two latency/depth configs
// on shared stimulus, checked against per-burst word queues.
module tb_ram_burst_reader;
  localparam int RL0 = 1;
  localparam int D0  = 4;
  localparam int RL1 = 3;
  localparam int D1  = 8;

  typedef struct {
    logic [7:0] base;
    int         len;
    int         mode;
    int         d0;
    int         d1;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_ready;
  logic [7:0]  i_base_addr;
  logic [8:0]  i_len;
  logic        busy  [2];
  logic        done  [2];
  logic        ren   [2];
  logic        valid [2];
  logic        last  [2];
  logic [7:0]  raddr [2];
  logic [63:0] data  [2];
  logic [63:0] rdata [2];
  logic [7:0]  gen;
  logic [7:0]  p0;
  logic [7:0]  p1 [3];
  logic [7:0]  ea0 [$];
  logic [7:0]  ea1 [$];
  logic [64:0] ed0 [$];
  logic [64:0] ed1 [$];
  int          n_cmp;
  int          n_bad;

  ram_burst_reader #(
    .DATA_W(64), .ADDR_W(8), .LEN_W(9),
    .RD_LATENCY(RL0), .FIFO_DEPTH(D0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_len(i_len),
    .o_busy(busy[0]), .o_done(done[0]),
    .o_raddr(raddr[0]), .o_ren(ren[0]),
    .i_rdata(rdata[0]), .o_valid(valid[0]),
    .i_ready(i_ready), .o_data(data[0]), .o_last(last[0])
  );

  ram_burst_reader #(
    .DATA_W(64), .ADDR_W(8), .LEN_W(9),
    .RD_LATENCY(RL1), .FIFO_DEPTH(D1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_len(i_len),
    .o_busy(busy[1]), .o_done(done[1]),
    .o_raddr(raddr[1]), .o_ren(ren[1]),
    .i_rdata(rdata[1]), .o_valid(valid[1]),
    .i_ready(i_ready), .o_data(data[1]), .o_last(last[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models: word = {generation tag, address}
  always @(posedge clk) begin
    p0    <= raddr[0];
    p1[0] <= raddr[1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rdata[0] = {gen, 48'h0, p0};
  assign rdata[1] = {gen, 48'h0, p1[2]};

  task automatic chk(input string nm, input bit ok,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    logic [7:0]  xa;
    logic [64:0] xd;
    if (rst_n && ren[0]) begin
      xa = (ea0.size() != 0) ? ea0[0] : 8'h0;
      chk("raddr0", ea0.size() != 0 && raddr[0] == xa,
          96'(raddr[0]), 96'(xa));
      if (ea0.size() != 0) void'(ea0.pop_front());
    end
    if (rst_n && valid[0]) begin
      xd = (ed0.size() != 0) ? ed0[0] : 65'h0;
      chk("data0", ed0.size() != 0 && {last[0], data[0]} == xd,
          96'({last[0], data[0]}), 96'(xd));
      if (i_ready && ed0.size() != 0) void'(ed0.pop_front());
    end
  end

  always @(negedge clk) begin : mon1
    logic [7:0]  xa;
    logic [64:0] xd;
    if (rst_n && ren[1]) begin
      xa = (ea1.size() != 0) ? ea1[0] : 8'h0;
      chk("raddr1", ea1.size() != 0 && raddr[1] == xa,
          96'(raddr[1]), 96'(xa));
      if (ea1.size() != 0) void'(ea1.pop_front());
    end
    if (rst_n && valid[1]) begin
      xd = (ed1.size() != 0) ? ed1[0] : 65'h0;
      chk("data1", ed1.size() != 0 && {last[1], data[1]} == xd,
          96'({last[1], data[1]}), 96'(xd));
      if (i_ready && ed1.size() != 0) void'(ed1.pop_front());
    end
  end

  task automatic push_exp(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      ea0.push_back(a);
      ea1.push_back(a);
      ed0.push_back({(i == len - 1), gen, 48'h0, a});
      ed1.push_back({(i == len - 1), gen, 48'h0, a});
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int k = 0; k < 2; k++) begin
      logic [76:0] v;
      v = {busy[k], done[k], raddr[k], ren[k],
           valid[k], last[k], data[k]};
      chk($sformatf("%s%0d", nm, k), v == '0, 96'(v), 96'(0));
    end
  endtask

  // mode 0: ready=1, 1: stall window, 2: random ready, 3: start poke
  task automatic run_burst(input logic [7:0] base, input int len,
                           input int mode, input int d0,
                           input int d1);
    int first [2];
    int dn    [2];
    int nv    [2];
    int iss   [2];
    int pop   [2];
    int mx    [2];
    int t;
    for (int k = 0; k < 2; k++) begin
      first[k] = -1; dn[k] = -1; nv[k] = 0;
      iss[k] = 0; pop[k] = 0; mx[k] = 0;
    end
    push_exp(base, len);
    i_base_addr = base;
    i_len       = 9'(len);
    i_start     = 1'b1;
    i_ready     = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    if (len > 0) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("first_addr%0d", k),
            ren[k] && raddr[k] == base,
            96'({ren[k], raddr[k]}), 96'({1'b1, base}));
      end
    end
    t = 0;
    while (t < 400 && (dn[0] < 0 || dn[1] < 0)) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      unique case (mode)
        1: i_ready = !(t >= 3 && t < 13);
        2: i_ready = ($urandom_range(0, 3) != 0);
        3: begin
          i_start     = (t == 3);
          i_base_addr = 8'h55;
          i_len       = 9'd3;
        end
        default: i_ready = 1'b1;
      endcase
      for (int k = 0; k < 2; k++) begin
        if (ren[k]) iss[k]++;
        if (iss[k] - pop[k] > mx[k]) mx[k] = iss[k] - pop[k];
        if (valid[k]) begin
          nv[k]++;
          if (first[k] < 0) first[k] = t;
        end
        if (valid[k] && i_ready) pop[k]++;
        if (done[k] && dn[k] < 0) dn[k] = t;
      end
      t++;
    end
    i_start = 1'b0;
    chk("done_seen", dn[0] >= 0 && dn[1] >= 0,
        96'({dn[0], dn[1]}), 96'(0));
    chk("credit0", mx[0] <= D0, 96'(mx[0]), 96'(D0));
    chk("credit1", mx[1] <= D1, 96'(mx[1]), 96'(D1));
    if (mode == 0 || mode == 3) begin
      for (int k = 0; k < 2; k++) begin
        int ef;
        int ed;
        ef = (len == 0) ? -1 : ((k == 0) ? RL0 : RL1) + 1;
        ed = (k == 0) ? d0 : d1;
        chk($sformatf("first_valid%0d", k), first[k] == ef,
            96'(first[k]), 96'(ef));
        chk($sformatf("done_lat%0d", k), dn[k] == ed,
            96'(dn[k]), 96'(ed));
        chk($sformatf("nvalid%0d", k), nv[k] == len,
            96'(nv[k]), 96'(len));
      end
    end
  endtask

  initial begin
    vec_t tbl [8];
    int   cnt;
    n_cmp       = 0;
    n_bad       = 0;
    gen         = 8'h5A;
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_ready     = 1'b1;
    i_base_addr = 8'h0;
    i_len       = 9'h0;

    tbl[0] = '{8'h10,  4, 0,  6,  8};
    tbl[1] = '{8'hFE,  4, 0,  6,  8};
    tbl[2] = '{8'h00, 16, 0, 18, 20};
    tbl[3] = '{8'h33,  0, 0,  1,  1};
    tbl[4] = '{8'h80,  1, 0,  3,  5};
    tbl[5] = '{8'hFF,  2, 0,  4,  6};
    tbl[6] = '{8'h40,  8, 3, 10, 12};
    tbl[7] = '{8'hC0,  8, 1,  0,  0};

    #12;
    chk_reset_vals("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_burst(tbl[i].base, tbl[i].len, tbl[i].mode,
                tbl[i].d0, tbl[i].d1);
    end

    for (int r = 0; r < 10; r++) begin
      int len;
      int md;
      len = $urandom_range(0, 20);
      md  = (r % 2 == 0) ? 2 : 0;
      run_burst(8'($urandom), len, md,
                (len == 0) ? 1 : len + RL0 + 1,
                (len == 0) ? 1 : len + RL1 + 1);
    end

    // Reset in the middle of a burst
    push_exp(8'h20, 12);
    i_base_addr = 8'h20;
    i_len       = 9'd12;
    i_ready     = 1'b1;
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cnt = 0;
    for (int t = 0; t < 50 && cnt < 3; t++) begin
      @(posedge clk); #1;
      if (valid[0] && i_ready) cnt++;
    end
    chk("rst_wait", cnt == 3, 96'(cnt), 96'(3));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    ea0.delete(); ea1.delete();
    ed0.delete(); ed1.delete();
    gen = 8'hA7;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(8'h70, 5, 0, 7, 9);

    repeat (4) @(posedge clk);
    #1;
    chk("left_a0", ea0.size() == 0, 96'(ea0.size()), 96'(0));
    chk("left_a1", ea1.size() == 0, 96'(ea1.size()), 96'(0));
    chk("left_d0", ed0.size() == 0, 96'(ed0.size()), 96'(0));
    chk("left_d1", ed1.size() == 0, 96'(ed1.size()), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
